// File: rtl/svga_pkg.sv
// svga_pkg
// Shared definitions for the SVGA pixel pipeline in the Laser310 video path.
// Contents:
//   - SVGA_DECODE_DELAY: pipeline depth, equal to the timing generator's decode lead.
//   - 12-bit 4:4:4 colour constants for the MC6847 palette.
//   - mode_e: per-pixel decode mode (TEXT, SEMI, GRAPH).
//   - Colour-index encoding passed from the S6 decode stage to the palette.
//   - side_t: per-pixel sideband that travels with each pixel down the pipeline.
package svga_pkg;

    localparam int SVGA_DECODE_DELAY = 7;

    localparam logic [11:0] COLOR_BLACK       = 12'h000;
    localparam logic [11:0] COLOR_GREEN       = 12'h0F0;
    localparam logic [11:0] COLOR_YELLOW      = 12'hFF0;
    localparam logic [11:0] COLOR_BLUE        = 12'h00F;
    localparam logic [11:0] COLOR_RED         = 12'hF00;
    localparam logic [11:0] COLOR_BUFF        = 12'hFFF;
    localparam logic [11:0] COLOR_CYAN        = 12'h0FF;
    localparam logic [11:0] COLOR_MAGENTA     = 12'hF0F;
    localparam logic [11:0] COLOR_ORANGE      = 12'hF80;
    localparam logic [11:0] COLOR_DARK_GREEN  = 12'h040;
    localparam logic [11:0] COLOR_DARK_ORANGE = 12'h420;

    typedef enum logic [1:0] {
        TEXT  = 2'd0,
        SEMI  = 2'd1,
        GRAPH = 2'd2
    } mode_e;

    // Colour index layout for SEMI/GRAPH: {set, black, c1, c0}.
    // With black clear, {set, c1, c0} is the MC6847 colour number 0..7
    // (green, yellow, blue, red, buff, cyan, magenta, orange), so the
    // graphics index {css, 1'b0, p} lands directly on the right colour set.
    // In TEXT mode only bit 0 matters: 1 = foreground dot, 0 = background.
    localparam logic [3:0] IDX_BLACK   = 4'b0100;
    localparam logic [3:0] IDX_TEXT_BG = 4'b0000;
    localparam logic [3:0] IDX_TEXT_FG = 4'b0001;

    // Sideband carried from S1 to S5. Character width is folded into
    // col/row/right at S1, so it does not need to travel further.
    typedef struct packed {
        logic       ag;
        logic [2:0] col;
        logic [3:0] row;
        logic       right;
        logic       bottom;
        logic [1:0] gpix;
    } side_t;

    // Map a 3-bit MC6847 colour number to its palette index.
    function automatic logic [3:0] colour_index(input logic [2:0] colour);
        return {colour[2], 1'b0, colour[1:0]};
    endfunction

endpackage

// File: rtl/svga_palette_6847.sv
// svga_palette_6847
// Combinational MC6847 palette lookup.
// Ports:
//   css   - colour set select (chooses text FG/BG pair)
//   mode  - decode mode of the pixel (TEXT uses FG/BG, others use colour index)
//   index - 4-bit colour index produced by the decode stage
//   rgb   - 12-bit 4:4:4 colour
module svga_palette_6847
    import svga_pkg::*;
(
    input  logic        css,
    input  mode_e       mode,
    input  logic [3:0]  index,
    output logic [11:0] rgb
);

    always_comb begin
        rgb = COLOR_BLACK;
        if (mode == TEXT) begin
            if (index[0]) begin
                rgb = css ? COLOR_ORANGE : COLOR_GREEN;
            end else begin
                rgb = css ? COLOR_DARK_ORANGE : COLOR_DARK_GREEN;
            end
        end else if (!index[2]) begin
            case ({index[3], index[1:0]})
                3'd0:    rgb = COLOR_GREEN;
                3'd1:    rgb = COLOR_YELLOW;
                3'd2:    rgb = COLOR_BLUE;
                3'd3:    rgb = COLOR_RED;
                3'd4:    rgb = COLOR_BUFF;
                3'd5:    rgb = COLOR_CYAN;
                3'd6:    rgb = COLOR_MAGENTA;
                default: rgb = COLOR_ORANGE;
            endcase
        end
    end

endmodule

// File: rtl/svga_pixel_pipeline.sv
// svga_pixel_pipeline
// Seven-stage pixel pipeline that turns timing-generator counters into one
// 12-bit RGB pixel per pixel_clock, emulating MC6847 text, semigraphics-4
// and 128x64 4-colour graphics.
// Ports:
//   pixel_clock, reset_n           - clock (rising edge), async active-low reset
//   ag, css, width_64              - mode, colour set, 64x32 text select
//   h_blank, v_blank, show_border  - pixel-aligned side inputs, used at S7
//   subchar_pixel/line, char_column/line - text counters
//   graph_pixel, graph_line_3x     - graphics counters
//   vram_addr / vram_data          - video RAM, data one clock after address
//   font_addr / font_data          - font ROM, data one clock after address
//   rgb, de                        - registered pixel colour and display enable
module svga_pixel_pipeline
    import svga_pkg::*;
#(
    parameter int VRAM_AW = 11,
    parameter int FONT_AW = 11
) (
    input  logic               pixel_clock,
    input  logic               reset_n,
    input  logic               ag,
    input  logic               css,
    input  logic               width_64,
    input  logic               h_blank,
    input  logic               v_blank,
    input  logic               show_border,
    input  logic [3:0]         subchar_pixel,
    input  logic [4:0]         subchar_line,
    input  logic [6:0]         char_column,
    input  logic [6:0]         char_line,
    input  logic [8:0]         graph_pixel,
    input  logic [9:0]         graph_line_3x,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [7:0]         vram_data,
    output logic [FONT_AW-1:0] font_addr,
    input  logic [7:0]         font_data,
    output logic [11:0]        rgb,
    output logic               de
);

    localparam int SIDE_STAGES = SVGA_DECODE_DELAY - 2;

    side_t       side_next;
    logic [10:0] addr_next;
    side_t       side_q [1:SIDE_STAGES];
    logic [7:0]  d_s3;
    logic [7:0]  d_s4;
    logic [7:0]  d_s5;
    logic [1:0]  gfx_pixel;
    logic [3:0]  index_next;
    logic [3:0]  index_s6;
    mode_e       mode_next;
    mode_e       mode_s6;
    logic [11:0] palette_rgb;

    // S1 decode: video RAM address and the in-cell position for this pixel.
    always_comb begin
        side_next      = '0;
        addr_next      = '0;
        side_next.ag   = ag;
        side_next.gpix = graph_pixel[3:2];
        if (width_64) begin
            side_next.col   = subchar_pixel[2:0];
            side_next.row   = subchar_line[3:0];
            side_next.right = subchar_pixel[2];
            addr_next       = {char_line[4:0], char_column[5:0]};
        end else begin
            side_next.col   = subchar_pixel[3:1];
            side_next.row   = subchar_line[4:1];
            side_next.right = subchar_pixel[3];
            addr_next       = {2'b00, char_line[3:0], char_column[4:0]};
        end
        side_next.bottom = (side_next.row >= 4'd6);
        if (ag) begin
            addr_next = {graph_line_3x[8:3], graph_pixel[8:4]};
        end
    end

    // S1..S5 sideband shift and the address/data stages S1, S3, S4, S5.
    // The font ROM's own output register acts as the S5 font latch, so
    // font_data is consumed directly by S6 alongside the forwarded d_s5.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i <= SIDE_STAGES; i++) begin
                side_q[i] <= '0;
            end
            vram_addr <= '0;
            font_addr <= '0;
            d_s3      <= '0;
            d_s4      <= '0;
            d_s5      <= '0;
        end else begin
            side_q[1] <= side_next;
            for (int i = 2; i <= SIDE_STAGES; i++) begin
                side_q[i] <= side_q[i-1];
            end
            vram_addr <= VRAM_AW'(addr_next);
            d_s3      <= vram_data;
            font_addr <= FONT_AW'({1'b0, d_s3[5:0], side_q[3].row});
            d_s4      <= d_s3;
            d_s5      <= d_s4;
        end
    end

    // S6 decode: pick the pixel's colour index from the VRAM byte and font row.
    always_comb begin
        mode_next  = TEXT;
        index_next = IDX_TEXT_BG;
        gfx_pixel  = 2'b00;
        if (side_q[SIDE_STAGES].ag) begin
            mode_next = GRAPH;
            case (side_q[SIDE_STAGES].gpix)
                2'd0:    gfx_pixel = d_s5[7:6];
                2'd1:    gfx_pixel = d_s5[5:4];
                2'd2:    gfx_pixel = d_s5[3:2];
                default: gfx_pixel = d_s5[1:0];
            endcase
            index_next = {css, 1'b0, gfx_pixel};
        end else if (d_s5[7]) begin
            // Quadrant bits: d3 top-left, d2 top-right, d1 bottom-left, d0 bottom-right.
            mode_next = SEMI;
            if (d_s5[{~side_q[SIDE_STAGES].bottom, ~side_q[SIDE_STAGES].right}]) begin
                index_next = colour_index(d_s5[6:4]);
            end else begin
                index_next = IDX_BLACK;
            end
        end else begin
            // Bit 6 of a text character selects inverse video.
            mode_next = TEXT;
            if (font_data[3'd7 - side_q[SIDE_STAGES].col] ^ d_s5[6]) begin
                index_next = IDX_TEXT_FG;
            end else begin
                index_next = IDX_TEXT_BG;
            end
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_s6  <= TEXT;
            index_s6 <= '0;
        end else begin
            mode_s6  <= mode_next;
            index_s6 <= index_next;
        end
    end

    svga_palette_6847 u_palette (
        .css   (css),
        .mode  (mode_s6),
        .index (index_s6),
        .rgb   (palette_rgb)
    );

    // S7 output select: blanking beats border, border beats picture.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            rgb <= '0;
            de  <= 1'b0;
        end else begin
            de <= ~(h_blank | v_blank);
            if (h_blank | v_blank) begin
                rgb <= COLOR_BLACK;
            end else if (show_border) begin
                if (mode_s6 == GRAPH) begin
                    rgb <= css ? COLOR_BUFF : COLOR_GREEN;
                end else begin
                    rgb <= COLOR_BLACK;
                end
            end else begin
                rgb <= palette_rgb;
            end
        end
    end

endmodule

// File: tb/tb_svga_pixel_pipeline.sv
// tb_svga_pixel_pipeline
// Scoreboard bench for svga_pixel_pipeline. Directed vectors carry their
// hand-computed vram_addr, font_addr, rgb and de. Issuing a vector pushes
// those into queues; a monitor tracks which edges carry a checked pixel
// and pops/compares vram_addr at +1, font_addr at +4 and rgb/de at +7.
module tb_svga_pixel_pipeline;

    logic        pixel_clock = 1'b0;
    logic        reset_n;
    logic        ag, css, width_64, h_blank, v_blank, show_border;
    logic [3:0]  subchar_pixel;
    logic [4:0]  subchar_line;
    logic [6:0]  char_column, char_line;
    logic [8:0]  graph_pixel;
    logic [9:0]  graph_line_3x;
    logic [10:0] vram_addr, font_addr;
    logic [7:0]  vram_data, font_data;
    logic [11:0] rgb;
    logic        de;

    typedef struct {
        logic        ag, w64, hb, vb, bd;
        logic [3:0]  sp;
        logic [4:0]  sl;
        logic [6:0]  cc, cl;
        logic [8:0]  gp;
        logic [9:0]  gl;
        logic [7:0]  vd, fd;
        logic [10:0] ev, ef;
        logic [11:0] er;
        logic        ede;
    } vec_t;

    vec_t        blk[$];
    logic [10:0] va_q[$];
    logic [10:0] fa_q[$];
    logic [12:0] px_q[$];
    logic        issued = 1'b0;
    logic [6:0]  sr;
    int          checks = 0;
    int          errors = 0;

    svga_pixel_pipeline dut (
        .pixel_clock   (pixel_clock),
        .reset_n       (reset_n),
        .ag            (ag),
        .css           (css),
        .width_64      (width_64),
        .h_blank       (h_blank),
        .v_blank       (v_blank),
        .show_border   (show_border),
        .subchar_pixel (subchar_pixel),
        .subchar_line  (subchar_line),
        .char_column   (char_column),
        .char_line     (char_line),
        .graph_pixel   (graph_pixel),
        .graph_line_3x (graph_line_3x),
        .vram_addr     (vram_addr),
        .vram_data     (vram_data),
        .font_addr     (font_addr),
        .font_data     (font_data),
        .rgb           (rgb),
        .de            (de)
    );

    // Free-running pixel clock.
    always #5 pixel_clock = ~pixel_clock;

    task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%03h, expected 0x%03h", name, actual, expected);
        end
    endtask

    task automatic reportUnderflow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got output slot with empty queue, expected a queued entry", name);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " rgb"}, rgb, 12'h000);
        checkOutput({tag, " de"}, {11'd0, de}, 12'h000);
        checkOutput({tag, " vram_addr"}, {1'b0, vram_addr}, 12'h000);
        checkOutput({tag, " font_addr"}, {1'b0, font_addr}, 12'h000);
    endtask

    task automatic addVec(input logic a, w, hb, vb, bd, input logic [3:0] sp, input logic [4:0] sl,
                          input logic [6:0] cc, cl, input logic [8:0] gp, input logic [9:0] gl,
                          input logic [7:0] vd, fd, input logic [10:0] ev, ef,
                          input logic [11:0] er, input logic ede);
        vec_t v;
        v.ag = a;   v.w64 = w;  v.hb = hb;  v.vb = vb;  v.bd = bd;
        v.sp = sp;  v.sl = sl;  v.cc = cc;  v.cl = cl;
        v.gp = gp;  v.gl = gl;  v.vd = vd;  v.fd = fd;
        v.ev = ev;  v.ef = ef;  v.er = er;  v.ede = ede;
        blk.push_back(v);
    endtask

    task automatic driveCounters(input vec_t v);
        ag            = v.ag;
        width_64      = v.w64;
        subchar_pixel = v.sp;
        subchar_line  = v.sl;
        char_column   = v.cc;
        char_line     = v.cl;
        graph_pixel   = v.gp;
        graph_line_3x = v.gl;
    endtask

    task automatic driveIdle();
        ag = 1'b0; width_64 = 1'b0;
        subchar_pixel = '0; subchar_line = '0; char_column = '0; char_line = '0;
        graph_pixel = '0; graph_line_3x = '0;
    endtask

    // Run the current block: each input is presented at the cycle its stage
    // consumes it (counters at +0, vram_data at +2, font_data at +5, side
    // inputs at +6), then drain the pipeline.
    task automatic applyStimulus(input logic css_value, input bit do_check);
        int n = blk.size();
        for (int c = 0; c < n + 8; c++) begin
            css = css_value;
            if (c < n) begin
                driveCounters(blk[c]);
                issued = do_check;
                if (do_check) begin
                    va_q.push_back(blk[c].ev);
                    fa_q.push_back(blk[c].ef);
                    px_q.push_back({blk[c].ede, blk[c].er});
                end
            end else begin
                driveIdle();
                issued = 1'b0;
            end
            vram_data = (c >= 2 && c - 2 < n) ? blk[c-2].vd : 8'h00;
            font_data = (c >= 5 && c - 5 < n) ? blk[c-5].fd : 8'h00;
            if (c >= 6 && c - 6 < n) begin
                h_blank = blk[c-6].hb; v_blank = blk[c-6].vb; show_border = blk[c-6].bd;
            end else begin
                h_blank = 1'b1; v_blank = 1'b0; show_border = 1'b0;
            end
            @(posedge pixel_clock);
            @(negedge pixel_clock);
        end
        issued = 1'b0;
        blk.delete();
    endtask

    // Monitor: follows checked pixels down the pipeline and compares each
    // output when that pixel's value is due.
    initial begin
        logic [10:0] ea;
        logic [12:0] ep;
        sr = '0;
        forever begin
            @(posedge pixel_clock);
            #1;
            sr = {sr[5:0], issued};
            if (sr[0]) begin
                if (va_q.size() == 0) reportUnderflow("vram_addr");
                else begin ea = va_q.pop_front(); checkOutput("vram_addr", {1'b0, vram_addr}, {1'b0, ea}); end
            end
            if (sr[3]) begin
                if (fa_q.size() == 0) reportUnderflow("font_addr");
                else begin ea = fa_q.pop_front(); checkOutput("font_addr", {1'b0, font_addr}, {1'b0, ea}); end
            end
            if (sr[6]) begin
                if (px_q.size() == 0) reportUnderflow("rgb");
                else begin
                    ep = px_q.pop_front();
                    checkOutput("rgb", rgb, ep[11:0]);
                    checkOutput("de", {11'd0, de}, {11'd0, ep[12]});
                end
            end
        end
    end

    // Main sequence: reset, text / semigraphics / graphics / border / blank
    // blocks for both colour sets, then a reset in the middle of active video.
    initial begin
        reset_n = 1'b0;
        css = 1'b0; h_blank = 1'b1; v_blank = 1'b0; show_border = 1'b0;
        vram_data = '0; font_data = '0;
        driveIdle();
        @(negedge pixel_clock);
        @(negedge pixel_clock);
        checkReset("reset");
        reset_n = 1'b1;

        $display("[TB] block css=0");
        addVec(0,0,0,0,0, 4'd0, 5'd6,  7'd5,  7'd2,  9'h000, 10'h000, 8'h01, 8'h80, 11'h045, 11'h013, 12'h0F0, 1);
        addVec(0,0,0,0,0, 4'd0, 5'd6,  7'd5,  7'd2,  9'h000, 10'h000, 8'h41, 8'h80, 11'h045, 11'h013, 12'h040, 1);
        addVec(0,1,0,0,0, 4'd3, 5'd5,  7'h6A, 7'h53, 9'h000, 10'h000, 8'h3F, 8'h10, 11'h4EA, 11'h3F5, 12'h0F0, 1);
        addVec(0,0,0,0,0, 4'd0, 5'd0,  7'd0,  7'd0,  9'h000, 10'h000, 8'hA8, 8'h00, 11'h000, 11'h280, 12'h00F, 1);
        addVec(0,0,0,0,0, 4'd8, 5'd0,  7'd0,  7'd0,  9'h000, 10'h000, 8'hA8, 8'h00, 11'h000, 11'h280, 12'h000, 1);
        addVec(0,0,0,0,0, 4'd8, 5'd12, 7'd0,  7'd0,  9'h000, 10'h000, 8'hF1, 8'h00, 11'h000, 11'h316, 12'hF80, 1);
        addVec(1,0,0,0,0, 4'd0, 5'd0,  7'd0,  7'd0,  9'h024, 10'h010, 8'h1B, 8'h00, 11'h042, 11'h1B0, 12'hFF0, 1);
        addVec(1,0,0,0,0, 4'd0, 5'd0,  7'd0,  7'd0,  9'h1FF, 10'h3FF, 8'h02, 8'h00, 11'h7FF, 11'h020, 12'h00F, 1);
        addVec(0,0,1,0,0, 4'd0, 5'd6,  7'd5,  7'd2,  9'h000, 10'h000, 8'h01, 8'h80, 11'h045, 11'h013, 12'h000, 0);
        addVec(0,0,0,1,0, 4'd0, 5'd6,  7'd5,  7'd2,  9'h000, 10'h000, 8'h01, 8'h80, 11'h045, 11'h013, 12'h000, 0);
        addVec(0,0,0,0,1, 4'd0, 5'd6,  7'd5,  7'd2,  9'h000, 10'h000, 8'h01, 8'h80, 11'h045, 11'h013, 12'h000, 1);
        addVec(1,0,0,0,1, 4'd0, 5'd0,  7'd0,  7'd0,  9'h024, 10'h010, 8'h1B, 8'h00, 11'h042, 11'h1B0, 12'h0F0, 1);
        applyStimulus(1'b0, 1'b1);

        $display("[TB] block css=1");
        addVec(0,0,0,0,0, 4'd0, 5'd6,  7'd5,  7'd2,  9'h000, 10'h000, 8'h41, 8'h80, 11'h045, 11'h013, 12'h420, 1);
        addVec(0,0,0,0,0, 4'd0, 5'd6,  7'd5,  7'd2,  9'h000, 10'h000, 8'h01, 8'h80, 11'h045, 11'h013, 12'hF80, 1);
        addVec(1,0,0,0,0, 4'd0, 5'd0,  7'd0,  7'd0,  9'h024, 10'h010, 8'h1B, 8'h00, 11'h042, 11'h1B0, 12'h0FF, 1);
        addVec(1,0,0,0,1, 4'd0, 5'd0,  7'd0,  7'd0,  9'h024, 10'h010, 8'h1B, 8'h00, 11'h042, 11'h1B0, 12'hFFF, 1);
        addVec(0,0,0,0,0, 4'd0, 5'd0,  7'd0,  7'd0,  9'h000, 10'h000, 8'hA8, 8'h00, 11'h000, 11'h280, 12'h00F, 1);
        addVec(1,0,1,0,1, 4'd0, 5'd0,  7'd0,  7'd0,  9'h024, 10'h010, 8'h1B, 8'h00, 11'h042, 11'h1B0, 12'h000, 0);
        applyStimulus(1'b1, 1'b1);

        $display("[TB] mid-line reset");
        css = 1'b0;
        addVec(0,0,0,0,0, 4'd0, 5'd6,  7'd5,  7'd2,  9'h000, 10'h000, 8'h01, 8'h80, 11'h045, 11'h013, 12'h0F0, 1);
        for (int c = 0; c < 9; c++) begin
            driveCounters(blk[0]);
            vram_data = 8'h01; font_data = 8'h80;
            h_blank = 1'b0; v_blank = 1'b0; show_border = 1'b0;
            @(posedge pixel_clock);
            @(negedge pixel_clock);
        end
        blk.delete();
        #2;
        reset_n = 1'b0;
        #1;
        checkReset("mid-line reset");
        repeat (3) @(posedge pixel_clock);
        #1;
        checkReset("reset held");
        @(negedge pixel_clock);
        reset_n = 1'b1;
        addVec(1,0,0,0,0, 4'd0, 5'd0,  7'd0,  7'd0,  9'h024, 10'h010, 8'h1B, 8'h00, 11'h042, 11'h1B0, 12'hFF0, 1);
        applyStimulus(1'b0, 1'b1);

        checkOutput("leftover expectations", 12'(va_q.size() + fa_q.size() + px_q.size()), 12'h000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/svga_pixel_pipeline.md
Name: svga_pixel_pipeline

Overview:
- Downstream consumer of the SVGA timing generator in the Laser310 video path.
- Takes its text/graphics counters, border and blank flags, fetches video RAM and font ROM, and produces one 12-bit RGB pixel per pixel_clock.
- Fixed 7-stage pipeline that matches the generator's 7-clock decode lead: fetch starts 7 clocks before the pixel is shown.
- Emulates the MC6847 modes: text 32x16 / 64x32, semigraphics-4, and graphics 128x64 4-colour.

Parameters:
- VRAM_AW, 11, video RAM address width.
- FONT_AW, 11, font ROM address width.

Ports:
- pixel_clock  in  1  pixel clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ag  in  1  0 = text/semigraphics, 1 = graphics 128x64 4-colour.
- css  in  1  colour set select.
- width_64  in  1  text 64x32 (8x12 cells) instead of 32x16 (16x24 cells).
- h_blank, v_blank  in  1  blanking from the timing generator.
- show_border  in  1  border region flag.
- subchar_pixel  in  4; subchar_line  in  5; char_column  in  7; char_line  in  7: text counters.
- graph_pixel  in  9; graph_line_3x  in  10: graphics counters.
- vram_addr  out  11  registered VRAM address.
- vram_data  in  8  sync-read VRAM data, valid 1 clock after vram_addr.
- font_addr  out  11  registered font ROM address.
- font_data  in  8  sync-read font data, valid 1 clock after font_addr; MSB = leftmost dot.
- rgb  out  12  registered pixel colour, 4:4:4.
- de  out  1  registered display enable = ~(h_blank|v_blank).

Behaviour:
- One pixel enters per clock, no stalls. Each stage carries ag, width_64, col/row sub-indices and graph_pixel[3:2].
- S1 registers vram_addr:
  - text 32x16: {2'b0, char_line[3:0], char_column[4:0]}.
  - text 64x32: {char_line[4:0], char_column[5:0]}.
  - graphics: {graph_line_3x[8:3], graph_pixel[8:4]}.
- S1 also latches:
  - cell column: subchar_pixel[3:1] for 32x16, subchar_pixel[2:0] for 64x32.
  - cell row: subchar_line[4:1] for 32x16, subchar_line[3:0] for 64x32.
  - half flags: right = subchar_pixel[3] (32x16) or [2] (64x32); bottom = row >= 6.
- S2: VRAM read in flight; sideband only advances.
- S3: latch vram_data as d.
- S4: font_addr <= {1'b0, d[5:0], row[3:0]}; d forwarded.
- S5: latch font_data as f.
- S6: build a 4-bit colour index:
  - ag=1: 2-bit pixel p = d[7-2k -: 2] with k = graph_pixel[3:2]; index = {css, 1'b0, p}.
  - text, d[7]=0: dot = f[7-col] XOR d[6]; index = dot ? FG : BG.
  - text, d[7]=1 (semigraphics): quadrant bit d[{~bottom, ~right}], i.e. d3 = top-left … d0 = bottom-right. Set selects colour d[6:4]; clear selects black.
- S7: registered output select, with side inputs sampled directly (already pixel-aligned):
  - if h_blank|v_blank: rgb = 0.
  - else if show_border: black in text mode; green (css=0) or buff (css=1) in graphics.
  - else: palette(index).
- Palette:
  - green 0x0F0, yellow 0xFF0, blue 0x00F, red 0xF00, buff 0xFFF, cyan 0x0FF, magenta 0xF0F, orange 0xF80.
  - text FG/BG: css=0 green 0x0F0 on dark green 0x040; css=1 orange 0xF80 on dark orange 0x420.
  - graphics sets: css=0 {green, yellow, blue, red}; css=1 {buff, cyan, magenta, orange}.
- Latency: counters at clock N → rgb at N+7. vram_addr changes at N+1, font_addr at N+4.
- Mode and width changes take effect per pixel as they traverse S1; no glitches, no flush. css is sampled at S6/S7.
- Reset (any time, mid-line included): every register goes to 0, i.e. rgb=0, de=0, vram_addr=0, font_addr=0. Output is valid 7 clocks after reset_n rises.
- Address arithmetic truncates: unused high counter bits are ignored.

Decomposition:
- Shared package svga_pkg holds:
  - 12-bit colour constants and the colour-index encoding.
  - stage count SVGA_DECODE_DELAY = 7.
  - the mode enum (TEXT, SEMI, GRAPH).
- One combinational sub-module, svga_palette_6847: css, mode and index in, 12-bit rgb out. Instantiated at S7.

Test Plan:
- Text 32x16: char_line=2, char_column=5, subchar_line=6, subchar_pixel=0. Expect vram_addr=0x045 at +1. With vram_data=0x01, expect font_addr=0x013 at +4. With font_data=0x80 and no border/blank, expect rgb=0x0F0 at +7.
- Inverse: same stimulus with vram_data=0x41 → rgb=0x040. With css=1 → 0x420.
- Semigraphics: vram_data=0xA8 (colour 2 = blue, top-left quadrant set), subchar_pixel=0, subchar_line=0 → rgb=0x00F. Same byte with subchar_pixel=8 → rgb=0x000.
- Graphics: ag=1, graph_line_3x=0x010, graph_pixel=0x024 → vram_addr=0x042. With vram_data=0x1B (k=1 → p=2'b01), css=0 → rgb=0xFF0; css=1 → rgb=0x0FF.
- Border/blank: show_border=1 with ag=1, css=1 → rgb=0xFFF. h_blank=1 → rgb=0, de=0, regardless of pipeline data.
- Reset mid-line: drop reset_n for 3 clocks during active pixels → outputs 0 immediately. After release, the first valid rgb appears at exactly +7.
